// File: rtl/char_scroller.sv
// char_scroller: LEN-entry message of 2-bit character codes with a 4-character
// window that scrolls one step per TICK_M enabled cycles. A write strobe in
// RUN starts a full-message reload (LOAD state); the window is visible live
// on c0..c3 (c0 = leftmost digit).
//
// Build option: define CHAR_SCROLLER_BOUNCE_EN for ping-pong mode, where pos
// sweeps 0..LEN-4 and back without wrapping and the dir input is ignored.
//
// Handshake: wr is a plain one-cycle-per-character strobe with no back
// pressure; every cycle with wr=1 consumes wr_data (first write in RUN lands
// in entry 0, the following LEN-1 writes in LOAD fill entries 1..LEN-1).
// The loading output is the FSM state bit (1 = LOAD, 0 = RUN).
module char_scroller #(
  parameter int TICK_M = 50000000,
  parameter int LEN    = 8
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   enable,
  input  logic                   dir,
  input  logic                   wr,
  input  logic [1:0]             wr_data,
  output logic                   tick,
  output logic [$clog2(LEN)-1:0] pos,
  output logic                   loading,
  output logic [1:0]             c0,
  output logic [1:0]             c1,
  output logic [1:0]             c2,
  output logic [1:0]             c3
);

  localparam int PW = $clog2(LEN);
  // Counter must hold 0..TICK_M-1.
  localparam int CW = (TICK_M > 1) ? $clog2(TICK_M) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_M - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(LEN - 1);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_LOAD = 1'b1;

  logic          state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pos_q;
  logic [PW-1:0] wp_q;
  logic [1:0]    msg_q [LEN];

  logic          in_run;
  logic          tick_w;
  logic          load_done;
  logic [PW-1:0] pos_step;

  // Window index with explicit modulo LEN (LEN need not be a power of two).
  function automatic logic [PW-1:0] win_idx(input logic [PW-1:0] p, input int k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    if (s >= (PW+1)'(LEN)) s = s - (PW+1)'(LEN);
    return s[PW-1:0];
  endfunction

  // Tick qualification: a write in RUN takes priority over a scroll step.
  always_comb begin
    in_run    = (state_q == ST_RUN);
    tick_w    = in_run && enable && (cnt_q == CNT_LAST) && !wr;
    load_done = !in_run && wr && (wp_q == POS_LAST);
  end

`ifdef CHAR_SCROLLER_BOUNCE_EN
  localparam logic [PW-1:0] BOUNCE_TOP = PW'(LEN - 4);

  logic fwd_q;
  logic fwd_step;
  logic unused_dir;

  assign unused_dir = dir;

  // Ping-pong step: reverse at either end of 0..LEN-4 instead of wrapping.
  always_comb begin
    pos_step = pos_q;
    fwd_step = fwd_q;
    if (LEN == 4) begin
      pos_step = '0;
    end else if (fwd_q) begin
      if (pos_q == BOUNCE_TOP) begin
        fwd_step = 1'b0;
        pos_step = pos_q - POS_ONE;
      end else begin
        pos_step = pos_q + POS_ONE;
      end
    end else begin
      if (pos_q == '0) begin
        fwd_step = 1'b1;
        pos_step = pos_q + POS_ONE;
      end else begin
        pos_step = pos_q - POS_ONE;
      end
    end
  end

  // Bounce direction flag: forward after reset and after every completed load.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      fwd_q <= 1'b1;
    end else if (load_done) begin
      fwd_q <= 1'b1;
    end else if (tick_w) begin
      fwd_q <= fwd_step;
    end
  end
`else
  // Modulo-LEN step in the direction selected by dir.
  always_comb begin
    pos_step = pos_q;
    if (dir) begin
      pos_step = (pos_q == '0) ? POS_LAST : (pos_q - POS_ONE);
    end else begin
      pos_step = (pos_q == POS_LAST) ? '0 : (pos_q + POS_ONE);
    end
  end
`endif

  // Control FSM, prescaler, window position and write pointer.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pos_q   <= '0;
      wp_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (wr) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            wp_q    <= POS_ONE;
          end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              pos_q <= pos_step;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_LOAD: begin
          cnt_q <= '0;
          if (wr) begin
            if (wp_q == POS_LAST) begin
              state_q <= ST_RUN;
              pos_q   <= '0;
              wp_q    <= '0;
            end else begin
              wp_q <= wp_q + POS_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
          pos_q   <= '0;
          wp_q    <= '0;
        end
      endcase
    end
  end

  // Message storage: reset pattern 0,1,2,3,0,1,...; writes land at entry 0
  // in RUN and at the write pointer in LOAD.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      for (int i = 0; i < LEN; i++) msg_q[i] <= 2'(i % 4);
    end else if (wr) begin
      if (state_q == ST_RUN) msg_q[0] <= wr_data;
      else                   msg_q[wp_q] <= wr_data;
    end
  end

  // Visible window, combinational from registered pos and storage.
  always_comb begin
    tick    = tick_w;
    pos     = pos_q;
    loading = (state_q == ST_LOAD);
    c0      = msg_q[win_idx(pos_q, 0)];
    c1      = msg_q[win_idx(pos_q, 1)];
    c2      = msg_q[win_idx(pos_q, 2)];
    c3      = msg_q[win_idx(pos_q, 3)];
  end

endmodule
